// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Holds the register offsets (word index = address[3:2]), the STATUS
// bit positions and the transmit state machine encoding.
package mmio_uart_tx_pkg;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/mmio_uart_tx_byte_fifo.sv
// byte_fifo: power-of-two deep byte FIFO with show-ahead output.
// Ports:
//   clock, reset_n   clock and asynchronous active-low reset
//   push, din        write strobe and byte; ignored while full
//   pop              read strobe; ignored while empty
//   dout             head byte (valid while not empty)
//   full, empty      occupancy flags
//   count            number of stored bytes (0..DEPTH)
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [7:0]                 din,
    output logic [7:0]                 dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage needs no reset; only pointers and count define occupancy.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a transmit FIFO.
// Ports:
//   clock, reset_n        system clock, asynchronous active-low reset
//   memory_write_en       CPU store strobe
//   memory_address        CPU byte address (16-byte window at BASE_ADDR)
//   memory_write_value    CPU store data
//   memory_read_value     combinational read data (STATUS or zero)
//   select                combinational address-hit flag
//   uart_tx               serial output, idle high
//
// Transmit FSM states:
//   state    | meaning
//   TX_IDLE  | line high, waiting for a queued byte
//   TX_START | start bit (low) for CLKS_PER_BIT cycles
//   TX_DATA  | 8 data bits, LSB first, CLKS_PER_BIT cycles each
//   TX_STOP  | stop bit (high); chains straight into the next frame
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        memory_write_en,
    input  logic [31:0] memory_address,
    input  logic [31:0] memory_write_value,
    output logic [31:0] memory_read_value,
    output logic        select,
    output logic        uart_tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    logic [1:0]    offset;
    logic          wr_data;
    logic          wr_status;
    logic          overflow;
    logic [3:0]    count_sat;
    logic [31:0]   status_word;

    logic          fifo_push;
    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    tx_state_e     state, state_next;
    logic [BW-1:0] baud, baud_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic [7:0]    shift, shift_next;
    logic          baud_last;

    logic          unused_bits;
    assign unused_bits = ^{memory_write_value[31:8], memory_address[1:0]};

    // ---------------- register interface ----------------
    assign select    = (memory_address[31:4] == BASE_ADDR[31:4]);
    assign offset    = memory_address[3:2];
    assign wr_data   = memory_write_en && select && (offset == OFF_DATA);
    assign wr_status = memory_write_en && select && (offset == OFF_STATUS);

    // Full is judged before the edge, so a same-edge pop never rescues a write.
    assign fifo_push = wr_data && !fifo_full;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (wr_data && fifo_full) begin
            overflow <= 1'b1;
        end else if (wr_status && memory_write_value[ST_OVF]) begin
            overflow <= 1'b0;
        end
    end

    always_comb begin
        count_sat = (32'(fifo_count) > 32'd15) ? 4'hF : 4'(fifo_count);
        status_word                     = '0;
        status_word[ST_FULL]            = fifo_full;
        status_word[ST_EMPTY]           = fifo_empty;
        status_word[ST_BUSY]            = (state != TX_IDLE);
        status_word[ST_OVF]             = overflow;
        status_word[ST_CNT_LSB +: 4]    = count_sat;
    end

    assign memory_read_value = (select && (offset == OFF_STATUS)) ? status_word : 32'h0;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     (memory_write_value[7:0]),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // ---------------- transmit FSM ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= TX_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_next;
            baud    <= baud_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
        end
    end

    assign baud_last = (baud == BAUD_LAST);

    always_comb begin
        state_next   = state;
        baud_next    = baud;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        fifo_pop     = 1'b0;
        case (state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    shift_next   = fifo_dout;
                    baud_next    = '0;
                    bit_idx_next = '0;
                    state_next   = TX_START;
                end
            end
            TX_START: begin
                if (baud_last) begin
                    baud_next  = '0;
                    state_next = TX_DATA;
                end else begin
                    baud_next = baud + BW'(1);
                end
            end
            TX_DATA: begin
                if (baud_last) begin
                    baud_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = TX_STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        shift_next   = {1'b0, shift[7:1]};
                    end
                end else begin
                    baud_next = baud + BW'(1);
                end
            end
            TX_STOP: begin
                if (baud_last) begin
                    baud_next = '0;
                    if (!fifo_empty) begin
                        fifo_pop     = 1'b1;
                        shift_next   = fifo_dout;
                        bit_idx_next = '0;
                        state_next   = TX_START;
                    end else begin
                        state_next = TX_IDLE;
                    end
                end else begin
                    baud_next = baud + BW'(1);
                end
            end
            default: state_next = TX_IDLE;
        endcase
    end

    // Line level depends only on registered state, never on the CPU bus.
    always_comb begin
        case (state)
            TX_START: uart_tx = 1'b0;
            TX_DATA:  uart_tx = shift[0];
            default:  uart_tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

    localparam int          N        = 4;
    localparam logic [31:0] BASE     = 32'hFFFF_0000;
    localparam logic [31:0] A_DATA   = 32'hFFFF_0000;
    localparam logic [31:0] A_STATUS = 32'hFFFF_0004;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        memory_write_en = 1'b0;
    logic [31:0] memory_address = 32'h0;
    logic [31:0] memory_write_value = 32'h0;
    logic [31:0] memory_read_value;
    logic        select;
    logic        uart_tx;

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (N),
        .FIFO_DEPTH   (8)
    ) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .memory_write_en    (memory_write_en),
        .memory_address     (memory_address),
        .memory_write_value (memory_write_value),
        .memory_read_value  (memory_read_value),
        .select             (select),
        .uart_tx            (uart_tx)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    int         frame_starts[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic write_reg(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clock);
        memory_address     = addr;
        memory_write_value = data;
        memory_write_en    = 1'b1;
        @(posedge clock);
        #1;
        memory_write_en    = 1'b0;
    endtask

    task automatic read_reg(input logic [31:0] addr, output logic [31:0] val, output logic sel);
        memory_address = addr;
        #1;
        val = memory_read_value;
        sel = select;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        logic [31:0] v;
        logic        s;
        v = 32'hx;
        for (int i = 0; i < budget; i++) begin
            read_reg(A_STATUS, v, s);
            if (v == 32'h2) break;
            @(posedge clock);
            #1;
        end
        check(name, v, 32'h2);
    endtask

    // Monitor: decodes frames off the line, checking every sample of every
    // bit so that bit length and framing are verified, then scores the byte.
    int         m_errs;
    bit         m_abort;
    logic [7:0] m_rx;
    logic       m_bv;
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n === 1'b1 && uart_tx === 1'b0) begin
                m_errs  = 0;
                m_abort = 1'b0;
                m_rx    = 8'h0;
                m_bv    = 1'b0;
                frame_starts.push_back(cyc);
                for (int k = 0; k < 10; k++) begin
                    for (int s = 0; s < N; s++) begin
                        if (k != 0 || s != 0) @(negedge clock);
                        if (reset_n !== 1'b1) m_abort = 1'b1;
                        if (s == 0) begin
                            if (k == 0)      m_bv = 1'b0;
                            else if (k == 9) m_bv = 1'b1;
                            else begin
                                m_bv        = uart_tx;
                                m_rx[k - 1] = uart_tx;
                            end
                        end
                        if (uart_tx !== m_bv) m_errs++;
                    end
                end
                if (!m_abort) begin
                    check("frame_shape", m_errs, 0);
                    if (exp_q.size() == 0) begin
                        check("frame_expected", {31'h0, exp_q.size() > 0}, 32'h1);
                    end else begin
                        check("rx_byte", {24'h0, m_rx}, {24'h0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic        s;
        int          e;
        int          idx0;
        int          nfr;

        // ---- reset and register window ----
        #1;
        check("uart_tx_in_reset", {31'h0, uart_tx}, 32'h1);
        read_reg(A_STATUS, v, s);
        check("status_in_reset", v, 32'h2);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        read_reg(A_STATUS, v, s);
        check("status_after_reset", v, 32'h0000_0002);
        check("select_hit", {31'h0, s}, 32'h1);
        check("uart_tx_idle", {31'h0, uart_tx}, 32'h1);
        read_reg(32'hFFFE_0004, v, s);
        check("select_miss", {31'h0, s}, 32'h0);
        check("read_miss", v, 32'h0);
        read_reg(A_DATA, v, s);
        check("read_data_reg", v, 32'h0);
        read_reg(32'hFFFF_000C, v, s);
        check("read_off3", v, 32'h0);

        // ---- single byte 0xA5: latency, bit timing, busy window ----
        exp_q.push_back(8'hA5);
        write_reg(A_DATA, 32'h0000_00A5);
        e = cyc;
        read_reg(A_STATUS, v, s);
        check("a5_status_queued", v, 32'h0000_0010);
        check("a5_line_high_at_E", {31'h0, uart_tx}, 32'h1);
        wait_cyc(e + 1);
        check("a5_line_low_E1", {31'h0, uart_tx}, 32'h0);
        read_reg(A_STATUS, v, s);
        check("a5_status_busy", v, 32'h0000_0006);
        wait_cyc(e + 40);
        read_reg(A_STATUS, v, s);
        check("a5_busy_at_E40", v, 32'h0000_0006);
        check("a5_stop_high", {31'h0, uart_tx}, 32'h1);
        wait_cyc(e + 41);
        read_reg(A_STATUS, v, s);
        check("a5_idle_at_E41", v, 32'h0000_0002);
        if (frame_starts.size() > 0)
            check("a5_start_cycle", frame_starts[frame_starts.size() - 1], e + 1);
        else
            check("a5_frame_seen", frame_starts.size(), 1);

        // ---- three back-to-back bytes, no gap between frames ----
        idx0 = frame_starts.size();
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        write_reg(A_DATA, 32'h11);
        write_reg(A_DATA, 32'h22);
        write_reg(A_DATA, 32'h33);
        wait_idle(300, "b2b_drain");
        check("b2b_frame_count", frame_starts.size() - idx0, 3);
        if (frame_starts.size() >= idx0 + 3) begin
            check("b2b_gap_1", frame_starts[idx0 + 1] - frame_starts[idx0], 10 * N);
            check("b2b_gap_2", frame_starts[idx0 + 2] - frame_starts[idx0 + 1], 10 * N);
        end

        // ---- overflow: 10 writes, first byte is popped before FIFO fills ----
        for (int i = 0; i < 10; i++) begin
            if (i < 9) exp_q.push_back(8'(8'h40 + i));
            write_reg(A_DATA, 32'h40 + i);
        end
        read_reg(A_STATUS, v, s);
        check("ovf_status_full", v, 32'h0000_008D);
        write_reg(A_STATUS, 32'h0000_00F7);
        read_reg(A_STATUS, v, s);
        check("ovf_kept_bit3_zero", v, 32'h0000_008D);
        write_reg(A_STATUS, 32'h0000_0008);
        read_reg(A_STATUS, v, s);
        check("ovf_cleared", v, 32'h0000_0085);
        wait_idle(600, "ovf_drain");

        // ---- reset during data bit 3 with bytes queued ----
        write_reg(A_DATA, 32'h52);
        e = cyc;
        write_reg(A_DATA, 32'h53);
        write_reg(A_DATA, 32'h54);
        write_reg(A_DATA, 32'h55);
        wait_cyc(e + 18);
        check("abort_bit3_low", {31'h0, uart_tx}, 32'h0);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_line_high", {31'h0, uart_tx}, 32'h1);
        read_reg(A_STATUS, v, s);
        check("abort_status_in_reset", v, 32'h2);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        nfr = frame_starts.size();
        repeat (150) @(posedge clock);
        #1;
        read_reg(A_STATUS, v, s);
        check("abort_status_after", v, 32'h0000_0002);
        check("abort_no_frames", frame_starts.size() - nfr, 0);

        check("exp_queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hFFFF_0000, meaning base of the 16-byte register window (bits [3:0] ignored).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit (legal range 2..65535).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning transmit FIFO entries (power of two, at least 2).
REQ-004 SHALL have these ports, one clock and asynchronous active-low reset:
- clock  input  1  system clock; all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- memory_write_en  input  1  CPU store strobe, sampled at clock edge.
- memory_address  input  32  CPU byte address.
- memory_write_value  input  32  CPU store data.
- memory_read_value  output  32  combinational read data.
- select  output  1  combinational address-hit flag.
- uart_tx  output  1  serial line, idle high.

Function
REQ-005 SHALL assert select combinationally iff memory_address[31:4] == BASE_ADDR[31:4]; register offset = memory_address[3:2].
REQ-006 SHALL decode offset 0 as DATA, write-only: a selected write pushes memory_write_value[7:0] into the FIFO at the clock edge.
REQ-007 SHALL decode offset 1 as STATUS: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits[7:4] FIFO count saturated at 15, bits[31:8] zero.
REQ-008 SHALL clear overflow on a selected write to STATUS with memory_write_value[3]=1; other STATUS write bits SHALL be ignored.
REQ-009 SHALL drive memory_read_value combinationally, in the same cycle as the address: STATUS contents when selected at offset 1, else 32'h0 (DATA, offsets 2-3, unselected).
REQ-010 SHALL drop a DATA write when the FIFO is full before the edge, set overflow, and leave FIFO contents unchanged, even if a pop occurs on the same edge.
REQ-011 SHALL run an FSM IDLE -> START -> DATA -> STOP, each bit lasting exactly CLKS_PER_BIT cycles.
REQ-012 IDLE: uart_tx=1; when the FIFO is non-empty at an edge, the FSM SHALL pop the head byte into a shift register and enter START.
REQ-013 START: uart_tx=0; DATA: uart_tx = shift register LSB, with 8 bits sent LSB first and a 3-bit index; STOP: uart_tx=1.
REQ-014 At the end of STOP the FSM SHALL go directly to START with the next byte if the FIFO is non-empty, else to IDLE, with no idle bit between frames.
REQ-015 A DATA write accepted at edge E into an empty FIFO while IDLE SHALL drive uart_tx low from edge E+1; each frame SHALL occupy 10*CLKS_PER_BIT cycles.
REQ-016 A simultaneous push and pop on a non-full FIFO SHALL leave the count unchanged and preserve order.
REQ-017 The baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap, with a width of $clog2(CLKS_PER_BIT).

Reset
REQ-018 While reset_n=0, asynchronously: FSM IDLE, uart_tx=1, FIFO empty (count 0, pointers 0), overflow 0, baud counter and bit index 0.
REQ-019 Reset asserted mid-frame SHALL abort the frame immediately (uart_tx high) and discard all queued bytes.
REQ-020 After reset the block SHALL report STATUS = 32'h0000_0002.

Structure
REQ-021 The shared package SHALL hold register offset constants (DATA=0, STATUS=1), STATUS bit positions, and the FSM state enum typedef.
REQ-022 The FIFO SHALL be a sub-module byte_fifo (push, pop, din, dout, full, empty, count) with the same clock and reset; everything else is in mmio_uart_tx.
REQ-023 The block SHALL have no combinational path from memory_write_value to uart_tx.

Verification
REQ-024 Reset then read 0xFFFF_0004 -> 32'h0000_0002; uart_tx=1; select=1; address 0xFFFE_0004 -> select=0, read 0.
REQ-025 CLKS_PER_BIT=4, write 0x0000_00A5 to 0xFFFF_0000 at edge E -> uart_tx low from E+1 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high; busy clears at E+41.
REQ-026 Write 0x11,0x22,0x33 back-to-back -> three contiguous frames, 30*CLKS_PER_BIT cycles, no idle gap, order preserved.
REQ-027 Write 10 bytes with FSM stalled by a long CLKS_PER_BIT -> STATUS full=1 and overflow=1, count field 8; first 8 bytes (or 9 if one is popped first) are sent; write 0x8 to STATUS -> overflow=0.
REQ-028 Assert reset_n low during the DATA bit 3 of a frame with 4 bytes queued -> uart_tx=1 immediately; after release STATUS=32'h2 and no further frames.
